// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: IF/ID/EX/MEM/WB sequencer with memory wait-state timeout,
// illegal-encoding trap and per-class instruction length.
module multicycle_ctrl_fsm #(
   parameter int FUNC_W   = 5,
   parameter int TIMEOUT  = 16,
   parameter int STRICT_M = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        opcode,
   input  logic              m,
   input  logic              gt,
   input  logic              lt,
   input  logic              eq,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              ir_en,
   output logic              reg_en,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        pc_src,
   output logic [1:0]        busw_src,
   output logic [1:0]        rw_sel,
   output logic [1:0]        opb_src,
   output logic              opa_src,
   output logic              sign_ext,
   output logic              wr_byte,
   output logic              sign_w2b,
   output logic [FUNC_W-1:0] alu_func,
   output logic [2:0]        state,
   output logic              instr_done,
   output logic              illegal,
   output logic              mem_fault
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IF   = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_EX   = 3'd3;
   localparam logic [2:0] S_MEM  = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;
   localparam logic [2:0] S_TRAP = 3'd6;

   logic [2:0] r_state, w_next;
   logic [3:0] r_op, w_op;
   logic       r_m, w_m;
   logic [7:0] r_wait;
   logic       r_illegal, r_fault;
   logic       w_itype, w_load, w_store, w_br, w_jmp, w_call, w_bad, w_taken;
   logic       w_active, w_wait, w_timeout, w_final;

   // In ID the class comes straight from IR; afterwards from the latched copy
   assign w_op      = (r_state == S_ID) ? opcode : r_op;
   assign w_m       = (r_state == S_ID) ? m : r_m;
   assign w_itype   = w_op == 4'd3 || w_op == 4'd4;
   assign w_load    = w_op == 4'd5 || w_op == 4'd6;
   assign w_store   = w_op == 4'd7 || w_op == 4'd15;
   assign w_br      = w_op[3:2] == 2'b10;
   assign w_jmp     = w_op[3:2] == 2'b11 && w_op != 4'd15;
   assign w_call    = w_op == 4'd13;
   assign w_bad     = STRICT_M != 0 && w_m && !(w_itype || w_op == 4'd6 || w_br);
   assign w_taken   = w_op[1] ? (w_op[0] ? !eq : eq) : (w_op[0] ? lt : gt);
   assign w_active  = r_state >= S_ID && r_state <= S_WB;
   assign w_wait    = (r_state == S_IF || r_state == S_MEM) && !mem_ready;
   assign w_timeout = w_wait && r_wait == 8'(TIMEOUT - 1);

   always_comb begin
      case (r_state)
         S_IDLE:  w_next = S_IF;
         S_IF:    w_next = w_timeout ? S_TRAP : mem_ready ? S_ID : S_IF;
         S_ID:    w_next = w_bad ? S_TRAP : w_jmp ? S_IF : S_EX;
         S_EX:    w_next = (w_load || w_store) ? S_MEM : w_br ? S_IF : S_WB;
         S_MEM:   w_next = w_timeout ? S_TRAP : !mem_ready ? S_MEM : w_load ? S_WB : S_IF;
         S_WB:    w_next = S_IF;
         default: w_next = S_TRAP;
      endcase
   end

   // Every return to IF from a working state is an instruction's last cycle
   assign w_final    = w_next == S_IF && r_state != S_IDLE && r_state != S_IF;
   assign pc_en      = w_final;
   assign instr_done = w_final;
   assign ir_en      = r_state == S_IF && mem_ready;
   assign mem_read   = r_state == S_IF || (r_state == S_MEM && w_load);
   assign mem_write  = r_state == S_MEM && w_store;
   assign reg_en     = r_state == S_WB || (w_final && w_call);
   assign pc_src     = (w_final && r_state == S_ID) ? (w_op == 4'd14 ? 2'b11 : 2'b10) :
                       (w_final && r_state == S_EX && w_taken) ? 2'b01 : 2'b00;
   assign busw_src   = !w_active ? 2'b00 : w_load ? 2'b01 : w_call ? 2'b10 : 2'b00;
   assign rw_sel     = (w_active && w_call) ? 2'b01 : 2'b00;
   assign opb_src    = !w_active ? 2'b00 : w_itype ? 2'b01 : (w_br && w_m) ? 2'b10 : 2'b00;
   assign opa_src    = 1'b0;
   assign sign_ext   = w_active && w_itype && w_m;
   assign wr_byte    = w_active && w_op == 4'd6;
   assign sign_w2b   = w_active && w_op == 4'd6 && w_m;
   assign alu_func   = w_active ? FUNC_W'({w_op, w_m}) : '0;
   assign state      = r_state;
   assign illegal    = r_illegal;
   assign mem_fault  = r_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_op      <= 4'd0;
         r_m       <= 1'b0;
         r_wait    <= 8'd0;
         r_illegal <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_op      <= w_op;
         r_m       <= w_m;
         r_wait    <= (w_wait && w_next == r_state) ? r_wait + 8'd1 : 8'd0;
         r_illegal <= r_illegal | (r_state == S_ID && w_bad);
         r_fault   <= r_fault | w_timeout;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: random instruction streams checked cycle by cycle against
// expected traces expanded from each instruction's class, wait counts and flags.
module tb_multicycle_ctrl_fsm;
   localparam int TO = 4;
   localparam logic [2:0] S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
   localparam logic [5:0] PC = 6'b100000, IR = 6'b010000, RG = 6'b001000, MR = 6'b000100, MW = 6'b000010, DN = 6'b000001;

   typedef struct {
      logic [2:0]  st;
      logic        rdy;
      logic [3:0]  op;
      logic        m;
      logic [2:0]  f;
      logic [5:0]  stb;
      logic [11:0] sel;
      logic [5:0]  alu;
      logic        ill;
      logic        flt;
   } cyc_t;

   logic clk = 1'b0, rst = 1'b1, m = 1'b0, gt = 1'b0, lt = 1'b0, eq = 1'b0, mem_ready = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic a_pc_en, a_ir_en, a_reg_en, a_mem_read, a_mem_write, a_opa_src, a_sign_ext, a_wr_byte, a_sign_w2b;
   logic a_instr_done, a_illegal, a_mem_fault;
   logic [1:0] a_pc_src, a_busw_src, a_rw_sel, a_opb_src;
   logic [5:0] a_alu_func;
   logic [2:0] a_state;
   logic b_pc_en, b_ir_en, b_reg_en, b_mem_read, b_mem_write, b_opa_src, b_sign_ext, b_wr_byte, b_sign_w2b;
   logic b_instr_done, b_illegal, b_mem_fault;
   logic [1:0] b_pc_src, b_busw_src, b_rw_sel, b_opb_src;
   logic [4:0] b_alu_func;
   logic [2:0] b_state;

   int n_chk = 0, n_fail = 0;
   cyc_t q[$];
   logic [3:0] cur_op;
   logic       cur_m;
   logic [2:0] cur_f;
   logic [9:0] cur_com;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.FUNC_W(6), .TIMEOUT(TO), .STRICT_M(1)) u_a (
      .clk(clk), .rst(rst), .opcode(opcode), .m(m), .gt(gt), .lt(lt), .eq(eq), .mem_ready(mem_ready),
      .pc_en(a_pc_en), .ir_en(a_ir_en), .reg_en(a_reg_en), .mem_read(a_mem_read), .mem_write(a_mem_write),
      .pc_src(a_pc_src), .busw_src(a_busw_src), .rw_sel(a_rw_sel), .opb_src(a_opb_src), .opa_src(a_opa_src),
      .sign_ext(a_sign_ext), .wr_byte(a_wr_byte), .sign_w2b(a_sign_w2b), .alu_func(a_alu_func),
      .state(a_state), .instr_done(a_instr_done), .illegal(a_illegal), .mem_fault(a_mem_fault));

   multicycle_ctrl_fsm #(.FUNC_W(5), .TIMEOUT(16), .STRICT_M(0)) u_b (
      .clk(clk), .rst(rst), .opcode(opcode), .m(m), .gt(gt), .lt(lt), .eq(eq), .mem_ready(mem_ready),
      .pc_en(b_pc_en), .ir_en(b_ir_en), .reg_en(b_reg_en), .mem_read(b_mem_read), .mem_write(b_mem_write),
      .pc_src(b_pc_src), .busw_src(b_busw_src), .rw_sel(b_rw_sel), .opb_src(b_opb_src), .opa_src(b_opa_src),
      .sign_ext(b_sign_ext), .wr_byte(b_wr_byte), .sign_w2b(b_sign_w2b), .alu_func(b_alu_func),
      .state(b_state), .instr_done(b_instr_done), .illegal(b_illegal), .mem_fault(b_mem_fault));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] dut_stb();
      return {a_pc_en, a_ir_en, a_reg_en, a_mem_read, a_mem_write, a_instr_done};
   endfunction

   function automatic logic [11:0] dut_sel();
      return {a_pc_src, a_busw_src, a_rw_sel, a_opb_src, a_opa_src, a_sign_ext, a_wr_byte, a_sign_w2b};
   endfunction

   task automatic push(input logic [2:0] st, input logic rdy, input logic [5:0] stb, input logic [1:0] pcs, input bit act);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.op = cur_op; c.m = cur_m;
      c.f = (st == S_EX) ? cur_f : 3'($urandom);
      c.stb = stb;
      c.sel = act ? {pcs, cur_com} : 12'd0;
      c.alu = act ? 6'({cur_op, cur_m}) : 6'd0;
      c.ill = 1'b0; c.flt = 1'b0;
      q.push_back(c);
   endtask

   task automatic push_trap(input logic ill, input logic flt);
      cyc_t c;
      for (int i = 0; i < 20; i++) begin
         c.st = S_TRAP; c.rdy = 1'($urandom); c.op = cur_op; c.m = cur_m; c.f = 3'($urandom);
         c.stb = 6'd0; c.sel = 12'd0; c.alu = 6'd0; c.ill = ill; c.flt = flt;
         q.push_back(c);
      end
   endtask

   // Expands one instruction into its expected cycle trace; returns 1 if it ends stuck (trap or abort)
   task automatic gen(input logic [3:0] op, input logic mm, input logic [2:0] f, input int iw, input int mw,
                      input bit abort, output bit stuck);
      bit needm = op inside {3, 4, 6, [8:11]};
      bit bad = mm && !needm;
      bit load = op inside {5, 6};
      bit store = op inside {7, 15};
      bit br = op inside {[8:11]};
      bit jmp = op inside {[12:14]};
      bit itype = op inside {3, 4};
      bit taken = (op == 8) ? f[2] : (op == 9) ? f[1] : (op == 10) ? f[0] : !f[0];
      logic [1:0] busw = load ? 2'b01 : (op == 13) ? 2'b10 : 2'b00;
      logic [1:0] opb = itype ? 2'b01 : (br && mm) ? 2'b10 : 2'b00;
      cur_op = op; cur_m = mm; cur_f = f;
      cur_com = {busw, (op == 13) ? 2'b01 : 2'b00, opb, 1'b0, itype && mm, op == 6, op == 6 && mm};
      stuck = 1'b1;
      for (int k = 0; k < iw && k < TO; k++) push(S_IF, 1'b0, MR, 2'b00, 1'b0);
      if (iw >= TO) begin push_trap(1'b0, 1'b1); return; end
      push(S_IF, 1'b1, IR | MR, 2'b00, 1'b0);
      if (bad) begin push(S_ID, 1'($urandom), 6'd0, 2'b00, 1'b1); push_trap(1'b1, 1'b0); return; end
      stuck = 1'b0;
      if (jmp) begin push(S_ID, 1'($urandom), PC | DN | ((op == 13) ? RG : 6'd0), (op == 14) ? 2'b11 : 2'b10, 1'b1); return; end
      push(S_ID, 1'($urandom), 6'd0, 2'b00, 1'b1);
      if (br) begin push(S_EX, 1'($urandom), PC | DN, taken ? 2'b01 : 2'b00, 1'b1); return; end
      push(S_EX, 1'($urandom), 6'd0, 2'b00, 1'b1);
      if (load || store) begin
         if (abort) begin push(S_MEM, 1'b0, load ? MR : MW, 2'b00, 1'b1); stuck = 1'b1; return; end
         for (int k = 0; k < mw && k < TO; k++) push(S_MEM, 1'b0, load ? MR : MW, 2'b00, 1'b1);
         if (mw >= TO) begin push_trap(1'b0, 1'b1); stuck = 1'b1; return; end
         push(S_MEM, 1'b1, load ? MR : (MW | PC | DN), 2'b00, 1'b1);
         if (store) return;
      end
      push(S_WB, 1'($urandom), RG | PC | DN, 2'b00, 1'b1);
   endtask

   task automatic run_q();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk); #1;
         opcode = c.op; m = c.m; mem_ready = c.rdy; {gt, lt, eq} = c.f;
         #1;
         check("state", 32'(a_state), 32'(c.st));
         check("strobes", 32'(dut_stb()), 32'(c.stb));
         check("selects", 32'(dut_sel()), 32'(c.sel));
         check("alu_func", 32'(a_alu_func), 32'(c.alu));
         check("illegal", 32'(a_illegal), 32'(c.ill));
         check("mem_fault", 32'(a_mem_fault), 32'(c.flt));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_ready = 1'b0; opcode = 4'($urandom); m = 1'($urandom);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_state", 32'(a_state), 32'd0);
         check("rst_strobes", 32'(dut_stb()), 32'd0);
         check("rst_selects", 32'(dut_sel()), 32'd0);
         check("rst_alu", 32'(a_alu_func), 32'd0);
         check("rst_flags", 32'({a_illegal, a_mem_fault}), 32'd0);
      end
      rst = 1'b0;
   endtask

   task automatic do_instr(input logic [3:0] op, input logic mm, input logic [2:0] f, input int iw, input int mw, input bit abort);
      bit stuck;
      gen(op, mm, f, iw, mw, abort, stuck);
      run_q();
      if (stuck) do_reset();
   endtask

   initial begin
      int bexp[4] = '{1, 2, 3, 5};
      do_reset();
      do_instr(4'd1, 1'b0, 3'b000, 0, 0, 1'b0);
      do_instr(4'd6, 1'b1, 3'b000, 0, 3, 1'b0);
      do_instr(4'd10, 1'b1, 3'b001, 0, 0, 1'b0);
      do_instr(4'd10, 1'b1, 3'b110, 0, 0, 1'b0);
      do_instr(4'd13, 1'b0, 3'b000, 0, 0, 1'b0);
      do_instr(4'd14, 1'b0, 3'b000, 0, 0, 1'b0);
      do_instr(4'd5, 1'b0, 3'b000, 0, 0, 1'b1);
      do_instr(4'd0, 1'b0, 3'b000, TO, 0, 1'b0);
      do_instr(4'd7, 1'b0, 3'b000, 0, TO, 1'b0);
      do_instr(4'd3, 1'b1, 3'b000, TO - 1, 0, 1'b0);
      do_instr(4'd6, 1'b0, 3'b000, 1, TO - 1, 1'b0);
      do_instr(4'd0, 1'b1, 3'b000, 0, 0, 1'b0);
      for (int i = 0; i < 150; i++) begin
         logic [3:0] op = 4'($urandom);
         logic mm = (op inside {3, 4, 6, [8:11]}) ? 1'($urandom) : ($urandom_range(0, 9) == 0);
         int iw = ($urandom_range(0, 20) == 0) ? TO : $urandom_range(0, TO - 1);
         int mw = ($urandom_range(0, 20) == 0) ? TO : $urandom_range(0, TO - 1);
         do_instr(op, mm, 3'($urandom), iw, mw, $urandom_range(0, 30) == 0);
      end
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         opcode = 4'd0; m = 1'b1; mem_ready = 1'b1; {gt, lt, eq} = 3'b000;
         #1;
         check("lax_state", 32'(b_state), 32'(bexp[i]));
         check("lax_done", 32'(b_instr_done), 32'(i == 3));
         check("lax_reg_en", 32'(b_reg_en), 32'(i == 3));
      end
      check("strict_trap", 32'(a_state), 32'(S_TRAP));
      check("strict_illegal", 32'(a_illegal), 32'd1);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
